operand_forward_unit: RTL and testbench
=======================================

// Module: operand_forward_unit
// PURPOSE
//  Parametrised operand-forwarding and hazard block for the 5-stage core (ID/EX/MEM/WB).
//  Tracks in-flight destination registers, computes per-operand forward selects in ID,
//  registers them into EX and drives the EX operand muxes.
//  Detects load-use hazards and raises a one-cycle ID stall.
//  Handles NUM_SRC operand channels and counts stall cycles for performance monitoring.
// PARAMETERS
//  DATA_W      32  operand/result width
//  REG_ADDR_W  4   register index width
//  NUM_SRC     2   operand channels (3 = A, B, store data)
//  ZERO_REG    0   1: register 0 is constant, never forwarded, never stalls
//  CNT_W       16  stall-counter width
// PORTS
//  clk            in   1                  core clock
//  rst            in   1                  synchronous active-high reset
//  id_valid       in   1                  valid instruction in ID
//  id_src_addr    in   NUM_SRC*REG_ADDR_W source register index per channel (ch i at [i*REG_ADDR_W +: REG_ADDR_W])
//  id_src_used    in   NUM_SRC            channel i reads a register
//  id_dst_addr    in   REG_ADDR_W         ID destination register
//  id_dst_we      in   1                  ID instruction writes dst
//  id_is_load     in   1                  ID instruction is a load
//  flush          in   1                  taken branch: kill ID and EX contents
//  ex_rf_data     in   NUM_SRC*DATA_W     register-file values latched into EX
//  ex_alt_data    in   NUM_SRC*DATA_W     immediate/PC per channel
//  ex_alt_sel     in   NUM_SRC            1: channel uses ex_alt_data
//  ex_mem_result  in   DATA_W             ALU result held in EX/MEM
//  mem_wb_result  in   DATA_W             writeback value held in MEM/WB (ALU or load)
//  stall          out  1                  hold PC and IF/ID; insert bubble into EX
//  ex_op          out  NUM_SRC*DATA_W     final EX operands
//  ex_fwd_sel     out  NUM_SRC*2          registered selects: 00 RF, 01 MEM, 10 WB, 11 ALT
//  stall_cnt      out  CNT_W              saturating count of stall cycles
// BEHAVIOUR
//  - Tracking entries EX and MEM each hold {valid, dst, we, is_load}.
//    Each edge: MEM <= EX; EX <= ID entry when (id_valid & ~stall & ~flush), else bubble.
//  - Selects per channel i, evaluated in ID:
//    alt_sel: the channel's select value registered in EX is taken from ex_alt_sel, which
//      arrives with the instruction in EX; ALT has priority over RF/MEM/WB.
//    match_EX:  EX.valid & EX.we & EX.dst == src.
//    match_MEM: MEM.valid & MEM.we & MEM.dst == src.
//    sel = match_EX ? MEM(01) : match_MEM ? WB(10) : RF(00).
//    The newest producer wins. sel is registered into ex_fwd_sel (1-cycle latency).
//    ex_fwd_sel reports 11 whenever ex_alt_sel[i] = 1.
//  - The register file is write-through, so a WB-stage producer needs no forward.
//  - ZERO_REG=1: src==0 forces sel=00 and never contributes to stall.
//  - stall (combinational) = id_valid & ~flush & any channel (used & match_EX & EX.is_load).
//    While stalled, ex_fwd_sel registers 00 for the bubble.
//    Next cycle the load is in MEM, the compare yields WB(10) and stall drops.
//    A stall therefore lasts exactly 1 cycle per load-use pair.
//  - ex_op[i] = ALT ? alt : 01 ? ex_mem_result : 10 ? mem_wb_result : ex_rf_data[i]
//    (combinational from registered sel).
//  - flush: at the edge, EX becomes a bubble and ex_fwd_sel becomes 00; MEM still advances.
//    flush forces stall=0 (flush beats stall).
//  - stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
//  - Reset: EX/MEM entries invalid, ex_fwd_sel=0, stall_cnt=0, stall=0.
//    ex_op then equals ex_rf_data or ex_alt_data.
//    Reset mid-stall drops stall on the next cycle and discards tracking.
// TESTING
//  1. Writes r3 then reads r3 as src0 back-to-back -> no stall; next cycle ex_fwd_sel[1:0]=01,
//     ex_op0=ex_mem_result (e.g. 0x0000_00AA).
//  2. r3 producer, independent instruction, then r3 consumer -> sel=10, ex_op0=mem_wb_result.
//  3. Load r5, then consumer of r5 on src1 -> stall=1 for exactly 1 cycle, stall_cnt 0->1;
//     consumer reaches EX with sel=10 and gets the load data.
//  4. EX and MEM both write r7, consumer reads r7 -> sel=01 (newest wins).
//     Consumer with ex_alt_sel=1 -> sel=11, ex_op=imm.
//  5. Load r2 + dependent consumer with flush in the same cycle -> stall=0; EX bubble next cycle.
//     ZERO_REG=1 with load r0 + consumer of r0 -> no stall, sel=00.
//  6. Assert rst during a stall -> next cycle stall=0, ex_fwd_sel=0, stall_cnt=0.
//     CNT_W=2 with 5 stalls -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/operand_forward_unit.sv
// Operand forwarding and load-use hazard unit for a 5-stage ID/EX/MEM/WB pipeline.
// Tracks in-flight destinations, registers per-channel forward selects into EX, and counts stall cycles.
module operand_forward_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int ZERO_REG   = 0,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_dst_addr,
    input  logic                          id_dst_we,
    input  logic                          id_is_load,
    input  logic                          flush,
    input  logic [NUM_SRC*DATA_W-1:0]     ex_rf_data,
    input  logic [NUM_SRC*DATA_W-1:0]     ex_alt_data,
    input  logic [NUM_SRC-1:0]            ex_alt_sel,
    input  logic [DATA_W-1:0]             ex_mem_result,
    input  logic [DATA_W-1:0]             mem_wb_result,
    output logic                          stall,
    output logic [NUM_SRC*DATA_W-1:0]     ex_op,
    output logic [NUM_SRC*2-1:0]          ex_fwd_sel,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam logic [1:0] SEL_ALT = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                  r_ex_valid;
    logic [REG_ADDR_W-1:0] r_ex_dst;
    logic                  r_ex_we;
    logic                  r_ex_load;
    logic                  r_mem_valid;
    logic [REG_ADDR_W-1:0] r_mem_dst;
    logic                  r_mem_we;
    logic                  r_mem_load;
    logic [NUM_SRC*2-1:0]  r_sel;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [NUM_SRC-1:0]    w_match_ex;
    logic [NUM_SRC-1:0]    w_match_mem;
    logic [NUM_SRC-1:0]    w_hazard;
    logic [NUM_SRC*2-1:0]  w_sel_id;
    logic                  w_advance;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_ch
            logic [REG_ADDR_W-1:0] w_src;
            logic                  w_is_zero;
            logic [1:0]            w_sel_ex;
            logic [DATA_W-1:0]     w_rf;
            logic [DATA_W-1:0]     w_alt;

            assign w_src     = id_src_addr[gi*REG_ADDR_W +: REG_ADDR_W];
            // A hard-wired zero register never produces a hazard or a forward.
            assign w_is_zero = (ZERO_REG != 0) && (w_src == '0);

            assign w_match_ex[gi]  = ~w_is_zero & r_ex_valid  & r_ex_we  & (r_ex_dst  == w_src);
            assign w_match_mem[gi] = ~w_is_zero & r_mem_valid & r_mem_we & (r_mem_dst == w_src);
            assign w_hazard[gi]    = id_src_used[gi] & w_match_ex[gi] & r_ex_load;

            // The EX producer is newer than the MEM producer, so it wins.
            assign w_sel_id[gi*2 +: 2] = w_match_ex[gi]  ? SEL_MEM :
                                         w_match_mem[gi] ? SEL_WB  : SEL_RF;

            assign w_sel_ex = ex_alt_sel[gi] ? SEL_ALT : r_sel[gi*2 +: 2];
            assign w_rf     = ex_rf_data[gi*DATA_W +: DATA_W];
            assign w_alt    = ex_alt_data[gi*DATA_W +: DATA_W];

            assign ex_fwd_sel[gi*2 +: 2]   = w_sel_ex;
            assign ex_op[gi*DATA_W +: DATA_W] = (w_sel_ex == SEL_ALT) ? w_alt         :
                                                (w_sel_ex == SEL_MEM) ? ex_mem_result :
                                                (w_sel_ex == SEL_WB)  ? mem_wb_result : w_rf;
        end
    endgenerate

    // A flush outranks a load-use stall: the dependent instruction is being killed anyway.
    assign stall     = id_valid & ~flush & (|w_hazard);
    assign w_advance = id_valid & ~stall & ~flush;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_dst    <= '0;
            r_ex_we     <= 1'b0;
            r_ex_load   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_dst   <= '0;
            r_mem_we    <= 1'b0;
            r_mem_load  <= 1'b0;
            r_sel       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_ex_valid  <= w_advance;
            r_ex_dst    <= id_dst_addr;
            r_ex_we     <= w_advance & id_dst_we;
            r_ex_load   <= w_advance & id_is_load;
            r_mem_valid <= r_ex_valid;
            r_mem_dst   <= r_ex_dst;
            r_mem_we    <= r_ex_we;
            r_mem_load  <= r_ex_load;
            // Bubbles (stall, flush or no instruction) carry an RF select.
            r_sel       <= w_advance ? w_sel_id : '0;
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_operand_forward_unit.sv
// Bench for operand_forward_unit: directed vector table, hand-written reset/saturation sequences,
// and random stimulus against a pipeline-history reference model; two instances (plain and zero-reg/2-bit counter).
module tb_operand_forward_unit;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NS = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [NS*AW-1:0] id_src_addr;
    logic [NS-1:0]    id_src_used;
    logic [AW-1:0]    id_dst_addr;
    logic             id_dst_we;
    logic             id_is_load;
    logic             flush;
    logic [NS*DW-1:0] ex_rf_data;
    logic [NS*DW-1:0] ex_alt_data;
    logic [NS-1:0]    ex_alt_sel;
    logic [DW-1:0]    ex_mem_result;
    logic [DW-1:0]    mem_wb_result;

    logic             stall0, stall1;
    logic [NS*DW-1:0] op0, op1;
    logic [NS*2-1:0]  fwd0, fwd1;
    logic [15:0]      cnt0;
    logic [1:0]       cnt1;

    always #5 clk = ~clk;

    operand_forward_unit #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .ZERO_REG(0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we), .id_is_load(id_is_load), .flush(flush),
        .ex_rf_data(ex_rf_data), .ex_alt_data(ex_alt_data), .ex_alt_sel(ex_alt_sel),
        .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
        .stall(stall0), .ex_op(op0), .ex_fwd_sel(fwd0), .stall_cnt(cnt0));

    operand_forward_unit #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .ZERO_REG(1), .CNT_W(2)) u_dut_z (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we), .id_is_load(id_is_load), .flush(flush),
        .ex_rf_data(ex_rf_data), .ex_alt_data(ex_alt_data), .ex_alt_sel(ex_alt_sel),
        .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
        .stall(stall1), .ex_op(op1), .ex_fwd_sel(fwd1), .stall_cnt(cnt1));

    int n_checks = 0;
    int n_err    = 0;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the two most recent issued instructions (age 0 = in EX, age 1 = in MEM).
    typedef struct packed {
        logic          v;
        logic [AW-1:0] dst;
        logic          we;
        logic          ld;
    } ent_t;

    ent_t        m_pipe [2][2];
    logic [1:0]  m_sel  [2][NS];
    int unsigned m_cnt  [2];

    function automatic int unsigned m_max(input int inst);
        return (inst == 0) ? 32'd65535 : 32'd3;
    endfunction

    function automatic logic [AW-1:0] src_of(input int ch);
        return id_src_addr[ch*AW +: AW];
    endfunction

    function automatic logic [1:0] m_src_sel(input int inst, input logic [AW-1:0] src);
        if (inst == 1 && src == '0) return 2'b00;
        for (int age = 0; age < 2; age++)
            if (m_pipe[inst][age].v && m_pipe[inst][age].we && m_pipe[inst][age].dst == src)
                return (age == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_stall(input int inst);
        if (!id_valid || flush) return 1'b0;
        for (int ch = 0; ch < NS; ch++) begin
            if (id_src_used[ch] && !(inst == 1 && src_of(ch) == '0) && m_pipe[inst][0].v &&
                m_pipe[inst][0].we && m_pipe[inst][0].ld && m_pipe[inst][0].dst == src_of(ch))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_check();
        logic [NS*2-1:0]  efwd;
        logic [NS*DW-1:0] eop;
        logic [1:0]       s;
        for (int i = 0; i < 2; i++) begin
            efwd = '0;
            eop  = '0;
            for (int ch = 0; ch < NS; ch++) begin
                s = ex_alt_sel[ch] ? 2'b11 : m_sel[i][ch];
                efwd[ch*2 +: 2] = s;
                case (s)
                    2'b11:   eop[ch*DW +: DW] = ex_alt_data[ch*DW +: DW];
                    2'b01:   eop[ch*DW +: DW] = ex_mem_result;
                    2'b10:   eop[ch*DW +: DW] = mem_wb_result;
                    default: eop[ch*DW +: DW] = ex_rf_data[ch*DW +: DW];
                endcase
            end
            if (i == 0) begin
                check("model_stall", 64'(stall0), 64'(m_stall(0)));
                check("model_fwd_sel", 64'(fwd0), 64'(efwd));
                check("model_ex_op", 64'(op0), 64'(eop));
                check("model_cnt", 64'(cnt0), 64'(m_cnt[0]));
            end else begin
                check("model_z_stall", 64'(stall1), 64'(m_stall(1)));
                check("model_z_fwd_sel", 64'(fwd1), 64'(efwd));
                check("model_z_ex_op", 64'(op1), 64'(eop));
                check("model_z_cnt", 64'(cnt1), 64'(m_cnt[1]));
            end
        end
    endtask

    task automatic model_advance();
        ent_t nw;
        logic st, adv;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pipe[i][0] = '0;
                m_pipe[i][1] = '0;
                m_cnt[i]     = 0;
                for (int ch = 0; ch < NS; ch++) m_sel[i][ch] = 2'b00;
            end else begin
                st  = m_stall(i);
                adv = id_valid && !st && !flush;
                if (st && m_cnt[i] < m_max(i)) m_cnt[i]++;
                for (int ch = 0; ch < NS; ch++) m_sel[i][ch] = adv ? m_src_sel(i, src_of(ch)) : 2'b00;
                nw = adv ? {1'b1, id_dst_addr, id_dst_we, id_is_load} : '0;
                m_pipe[i][1] = m_pipe[i][0];
                m_pipe[i][0] = nw;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (model_on) model_check();
    endtask

    task automatic advance();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used,
                         input logic [3:0] d, input logic we, input logic ld, input logic fl, input logic [1:0] alt);
        id_valid    = v;
        id_src_addr = {s1, s0};
        id_src_used = used;
        id_dst_addr = d;
        id_dst_we   = we;
        id_is_load  = ld;
        flush       = fl;
        ex_alt_sel  = alt;
    endtask

    typedef struct {
        logic        v;
        logic [3:0]  s0, s1;
        logic [1:0]  used;
        logic [3:0]  d;
        logic        we, ld, fl;
        logic [1:0]  alt;
        logic        e_st, e_st_z;
        logic [3:0]  e_sel, e_sel_z;
        logic [15:0] e_cnt;
        logic [1:0]  e_cnt_z;
        logic [63:0] e_op;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used,
                                input logic [3:0] d, input logic we, input logic ld, input logic fl,
                                input logic [1:0] alt, input logic est, input logic estz, input logic [3:0] esel,
                                input logic [3:0] eselz, input logic [15:0] ecnt, input logic [1:0] ecntz,
                                input logic [63:0] eop);
        vec_t r;
        r.v = v; r.s0 = s0; r.s1 = s1; r.used = used; r.d = d; r.we = we; r.ld = ld; r.fl = fl; r.alt = alt;
        r.e_st = est; r.e_st_z = estz; r.e_sel = esel; r.e_sel_z = eselz; r.e_cnt = ecnt; r.e_cnt_z = ecntz;
        r.e_op = eop;
        return r;
    endfunction

    localparam logic [63:0] OP_RR = 64'h00000101_00000100;

    vec_t tbl [20];

    initial begin
        // Row N: instruction in ID this cycle; expectations are what is visible at this cycle's sample point.
        tbl[0]  = mk(1, 15, 15, 2'b00, 3,  1, 0, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 0, 0, OP_RR);
        tbl[1]  = mk(1, 3,  15, 2'b01, 4,  1, 0, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 0, 0, OP_RR);
        tbl[2]  = mk(1, 15, 15, 2'b00, 8,  1, 0, 0, 2'b00, 0, 0, 4'b0001, 4'b0001, 0, 0, 64'h00000101_000000AA);
        tbl[3]  = mk(1, 15, 15, 2'b00, 9,  1, 0, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 0, 0, OP_RR);
        tbl[4]  = mk(1, 8,  15, 2'b01, 10, 1, 0, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 0, 0, OP_RR);
        tbl[5]  = mk(1, 15, 15, 2'b00, 5,  1, 1, 0, 2'b00, 0, 0, 4'b0010, 4'b0010, 0, 0, 64'h00000101_000000BB);
        tbl[6]  = mk(1, 15, 5,  2'b10, 11, 1, 0, 0, 2'b00, 1, 1, 4'b0000, 4'b0000, 0, 0, OP_RR);
        tbl[7]  = mk(1, 15, 5,  2'b10, 11, 1, 0, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 1, 1, OP_RR);
        tbl[8]  = mk(1, 15, 15, 2'b00, 7,  1, 0, 0, 2'b00, 0, 0, 4'b1000, 4'b1000, 1, 1, 64'h000000BB_00000100);
        tbl[9]  = mk(1, 15, 15, 2'b00, 7,  1, 0, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 1, 1, OP_RR);
        tbl[10] = mk(1, 7,  7,  2'b11, 12, 1, 0, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 1, 1, OP_RR);
        tbl[11] = mk(1, 7,  15, 2'b01, 13, 1, 0, 0, 2'b00, 0, 0, 4'b0101, 4'b0101, 1, 1, 64'h000000AA_000000AA);
        tbl[12] = mk(1, 15, 15, 2'b00, 0,  0, 0, 0, 2'b01, 0, 0, 4'b0011, 4'b0011, 1, 1, 64'h00000101_00000200);
        tbl[13] = mk(1, 15, 15, 2'b00, 2,  1, 1, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 1, 1, OP_RR);
        tbl[14] = mk(1, 2,  15, 2'b01, 14, 1, 0, 1, 2'b00, 0, 0, 4'b0000, 4'b0000, 1, 1, OP_RR);
        tbl[15] = mk(1, 15, 15, 2'b00, 1,  0, 0, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 1, 1, OP_RR);
        tbl[16] = mk(1, 15, 15, 2'b00, 0,  1, 1, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 1, 1, OP_RR);
        tbl[17] = mk(1, 0,  15, 2'b01, 1,  0, 0, 0, 2'b00, 1, 0, 4'b0000, 4'b0000, 1, 1, OP_RR);
        tbl[18] = mk(1, 0,  15, 2'b01, 1,  0, 0, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 2, 1, OP_RR);
        tbl[19] = mk(0, 15, 15, 2'b00, 0,  0, 0, 0, 2'b00, 0, 0, 4'b0010, 4'b0000, 2, 1, 64'h00000101_000000BB);

        rst           = 1'b1;
        ex_rf_data    = {32'h101, 32'h100};
        ex_alt_data   = {32'h201, 32'h200};
        ex_mem_result = 32'hAA;
        mem_wb_result = 32'hBB;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
        advance();
        advance();
        rst      = 1'b0;
        model_on = 1'b1;

        for (int r = 0; r < 20; r++) begin
            drive(tbl[r].v, tbl[r].s0, tbl[r].s1, tbl[r].used, tbl[r].d, tbl[r].we, tbl[r].ld, tbl[r].fl, tbl[r].alt);
            sample();
            $display("row %0d: stall=%0b/%0b sel=%b/%b cnt=%0d/%0d op=%h", r, stall0, stall1, fwd0, fwd1,
                     cnt0, cnt1, op0);
            check("tbl_stall", 64'(stall0), 64'(tbl[r].e_st));
            check("tbl_z_stall", 64'(stall1), 64'(tbl[r].e_st_z));
            check("tbl_sel", 64'(fwd0), 64'(tbl[r].e_sel));
            check("tbl_z_sel", 64'(fwd1), 64'(tbl[r].e_sel_z));
            check("tbl_cnt", 64'(cnt0), 64'(tbl[r].e_cnt));
            check("tbl_z_cnt", 64'(cnt1), 64'(tbl[r].e_cnt_z));
            check("tbl_op", op0, tbl[r].e_op);
            advance();
        end

        // Reset asserted in the middle of a load-use stall.
        drive(1, 15, 15, 2'b00, 5, 1, 1, 0, 2'b00);
        sample();
        advance();
        drive(1, 5, 15, 2'b01, 6, 1, 0, 0, 2'b00);
        rst = 1'b1;
        sample();
        $display("reset-in-stall: stall=%0b cnt=%0d", stall0, cnt0);
        check("rst_stall_before", 64'(stall0), 64'd1);
        advance();
        rst = 1'b0;
        sample();
        $display("after reset: stall=%0b sel=%b cnt=%0d/%0d", stall0, fwd0, cnt0, cnt1);
        check("rst_stall_after", 64'(stall0), 64'd0);
        check("rst_sel_after", 64'(fwd0), 64'd0);
        check("rst_cnt_after", 64'(cnt0), 64'd0);
        check("rst_z_cnt_after", 64'(cnt1), 64'd0);
        advance();

        // Five load-use pairs: the 2-bit counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            drive(1, 15, 15, 2'b00, 5, 1, 1, 0, 2'b00);
            sample();
            advance();
            drive(1, 5, 15, 2'b01, 6, 1, 0, 0, 2'b00);
            sample();
            check("sat_stall", 64'(stall0), 64'd1);
            advance();
            sample();
            check("sat_stall_drop", 64'(stall0), 64'd0);
            advance();
            $display("load-use pair %0d: cnt=%0d/%0d", k, cnt0, cnt1);
        end
        drive(0, 15, 15, 2'b00, 0, 0, 0, 0, 2'b00);
        sample();
        check("sat_cnt_main", 64'(cnt0), 64'd5);
        check("sat_cnt_z", 64'(cnt1), 64'd3);
        advance();

        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 49) == 0);
            ex_rf_data    = {$urandom, $urandom};
            ex_alt_data   = {$urandom, $urandom};
            ex_mem_result = $urandom;
            mem_wb_result = $urandom;
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                  (($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00));
            sample();
            $display("rand %0d: rst=%0b stall=%0b/%0b sel=%b/%b cnt=%0d/%0d", n, rst, stall0, stall1,
                     fwd0, fwd1, cnt0, cnt1);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
